// File: rtl/iomem_gpio.sv
// iomem_gpio: parametrised GPIO peripheral for the PicoSoC iomem bus.
// Per-pin direction, synchronised inputs, atomic set/clear, edge capture
// with a registered level interrupt. One-cycle acknowledged bus slave.
module iomem_gpio #(
  parameter int unsigned      WIDTH       = 32,
  parameter logic [7:0]       ADDR_HI     = 8'h03,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] OUT_RESET   = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             iomem_valid,
  output logic             iomem_ready,
  input  logic [3:0]       iomem_wstrb,
  input  logic [31:0]      iomem_addr,
  input  logic [31:0]      iomem_wdata,
  output logic [31:0]      iomem_rdata,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  localparam logic [2:0] OFF_OUT    = 3'd0;
  localparam logic [2:0] OFF_DIR    = 3'd1;
  localparam logic [2:0] OFF_IN     = 3'd2;
  localparam logic [2:0] OFF_RISE   = 3'd3;
  localparam logic [2:0] OFF_FALL   = 3'd4;
  localparam logic [2:0] OFF_STATUS = 3'd5;
  localparam logic [2:0] OFF_SET    = 3'd6;
  localparam logic [2:0] OFF_CLR    = 3'd7;

  logic [WIDTH-1:0] out_q,     out_d;
  logic [WIDTH-1:0] dir_q,     dir_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] status_q,  status_d;
  logic [WIDTH-1:0] prev_q,    prev_d;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic             ready_q,   ready_d;
  logic [31:0]      rdata_q,   rdata_d;

  logic             sel;
  logic [2:0]       off;
  logic [31:0]      byte_mask;
  logic [31:0]      wdata_masked;
  logic [WIDTH-1:0] wmask;
  logic [WIDTH-1:0] wbits;
  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] edge_evt;
  logic [31:0]      rd_val;

  // Address bits outside the block select and register offset are don't-care.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{iomem_addr[23:5], iomem_addr[1:0]};

  // Decode the access and build the per-lane write mask, clipped to WIDTH.
  always_comb begin
    sel          = iomem_valid && !ready_q && (iomem_addr[31:24] == ADDR_HI);
    off          = iomem_addr[4:2];
    byte_mask    = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                    {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
    wdata_masked = iomem_wdata & byte_mask;
    wmask        = byte_mask[WIDTH-1:0];
    wbits        = wdata_masked[WIDTH-1:0];
  end

  // Input synchroniser, previous-value register and edge detection.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], gpio_in};
    sync_in  = sync_q[SYNC_STAGES-1];
    prev_d   = sync_in;
    edge_evt = (sync_in & ~prev_q & rise_en_q) | (~sync_in & prev_q & fall_en_q);
  end

  // Read mux: current register values, so a write in the same access is not seen.
  always_comb begin
    rd_val = '0;
    case (off)
      OFF_OUT:    rd_val[WIDTH-1:0] = out_q;
      OFF_DIR:    rd_val[WIDTH-1:0] = dir_q;
      OFF_IN:     rd_val[WIDTH-1:0] = sync_in;
      OFF_RISE:   rd_val[WIDTH-1:0] = rise_en_q;
      OFF_FALL:   rd_val[WIDTH-1:0] = fall_en_q;
      OFF_STATUS: rd_val[WIDTH-1:0] = status_q;
      default:    rd_val = '0;
    endcase
  end

  // Register writes, W1C status with edge events taking priority, bus response.
  always_comb begin
    out_d     = out_q;
    dir_d     = dir_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    status_d  = status_q;
    if (sel) begin
      case (off)
        OFF_OUT:    out_d     = (out_q & ~wmask) | wbits;
        OFF_DIR:    dir_d     = (dir_q & ~wmask) | wbits;
        OFF_RISE:   rise_en_d = (rise_en_q & ~wmask) | wbits;
        OFF_FALL:   fall_en_d = (fall_en_q & ~wmask) | wbits;
        OFF_STATUS: status_d  = status_q & ~wbits;
        OFF_SET:    out_d     = out_q | wbits;
        OFF_CLR:    out_d     = out_q & ~wbits;
        default:    out_d     = out_q;
      endcase
    end
    status_d = status_d | edge_evt;
    ready_d  = sel;
    rdata_d  = sel ? rd_val : rdata_q;
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q     <= OUT_RESET;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      sync_q    <= '0;
      prev_q    <= '0;
      ready_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      out_q     <= out_d;
      dir_q     <= dir_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      ready_q   <= ready_d;
      rdata_q   <= rdata_d;
    end
  end

  assign gpio_out    = out_q;
  assign gpio_oe     = dir_q;
  assign irq         = |status_q;
  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;

endmodule

// File: tb/tb_iomem_gpio.sv
// Testbench for iomem_gpio: directed vector table, hand-written corner
// sequences and a randomized run, all against a history-based reference model.
module tb_iomem_gpio;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        iomem_valid = 1'b0;
  logic [3:0]  iomem_wstrb = 4'h0;
  logic [31:0] iomem_addr = 32'h0;
  logic [31:0] iomem_wdata = 32'h0;
  logic [31:0] gpio_in = 32'h0;

  logic        ready, irq;
  logic [31:0] rdata, gpio_out, gpio_oe;
  logic        ready8, irq8;
  logic [31:0] rdata8;
  logic [7:0]  out8, oe8;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  iomem_gpio #(.WIDTH(32), .ADDR_HI(8'h03), .SYNC_STAGES(S), .OUT_RESET(32'h1)) u_dut (
    .clk(clk), .reset(reset), .iomem_valid(iomem_valid), .iomem_ready(ready),
    .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata),
    .iomem_rdata(rdata), .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe),
    .irq(irq));

  iomem_gpio #(.WIDTH(8), .ADDR_HI(8'h04), .SYNC_STAGES(S), .OUT_RESET(8'h01)) u_dut8 (
    .clk(clk), .reset(reset), .iomem_valid(iomem_valid), .iomem_ready(ready8),
    .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata),
    .iomem_rdata(rdata8), .gpio_in(gpio_in[7:0]), .gpio_out(out8), .gpio_oe(oe8),
    .irq(irq8));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model of the 32-bit instance. IN is the pin value seen SYNC_STAGES
  // edges ago (kept as a sample history); STATUS picks up an edge one clock after
  // IN shows it; bus effects follow the register map rules directly.
  logic [31:0] m_out, m_dir, m_rise, m_fall, m_status, m_rdata;
  logic        m_ready;
  logic [31:0] samp [0:S];

  always @(posedge clk) begin : model
    logic [31:0] ev, mask, wm, rv;
    logic        sel;
    if (reset) begin
      m_out = 32'h1; m_dir = 0; m_rise = 0; m_fall = 0; m_status = 0;
      m_rdata = 0; m_ready = 1'b0;
      for (int i = 0; i <= S; i++) samp[i] = 32'h0;
    end else begin
      ev  = (samp[S-1] & ~samp[S] & m_rise) | (~samp[S-1] & samp[S] & m_fall);
      sel = iomem_valid && !m_ready && (iomem_addr[31:24] == 8'h03);
      if (sel) begin
        case (iomem_addr[4:2])
          3'd0: rv = m_out;
          3'd1: rv = m_dir;
          3'd2: rv = samp[S-1];
          3'd3: rv = m_rise;
          3'd4: rv = m_fall;
          3'd5: rv = m_status;
          default: rv = 32'h0;
        endcase
        m_rdata = rv;
        mask = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}}, {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
        wm   = iomem_wdata & mask;
        case (iomem_addr[4:2])
          3'd0: m_out    = (m_out & ~mask) | wm;
          3'd1: m_dir    = (m_dir & ~mask) | wm;
          3'd3: m_rise   = (m_rise & ~mask) | wm;
          3'd4: m_fall   = (m_fall & ~mask) | wm;
          3'd5: m_status = m_status & ~wm;
          3'd6: m_out    = m_out | wm;
          3'd7: m_out    = m_out & ~wm;
          default: ;
        endcase
      end
      m_status = m_status | ev;
      m_ready  = sel;
      for (int i = S; i > 0; i--) samp[i] = samp[i-1];
      samp[0] = gpio_in;
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_ready", 32'(ready), 32'(m_ready));
      check("m_rdata", rdata, m_rdata);
      check("m_gpio_out", gpio_out, m_out);
      check("m_gpio_oe", gpio_oe, m_dir);
      check("m_irq", 32'(irq), 32'(|m_status));
    end
  end

  logic        lat_ready, lat_ready8, lat_irq, post_ready;
  logic [31:0] lat_rdata, lat_rdata8, lat_out, lat_oe, lat_oe8;

  // Called at a negedge: request sampled at the next edge, outputs captured in
  // the following (ready) cycle, then one idle cycle.
  task automatic bus(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    iomem_valid = 1'b1; iomem_addr = a; iomem_wstrb = s; iomem_wdata = d;
    @(negedge clk);
    lat_ready = ready; lat_rdata = rdata; lat_out = gpio_out; lat_oe = gpio_oe;
    lat_irq = irq; lat_ready8 = ready8; lat_rdata8 = rdata8; lat_oe8 = 32'(oe8);
    iomem_valid = 1'b0; iomem_wstrb = 4'h0;
    @(negedge clk);
    post_ready = ready;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
    logic        rdy;
    logic [31:0] rdata;
    logic [31:0] out;
    logic [31:0] oe;
  } vec_t;

  vec_t vt [13];

  initial begin
    logic [7:0]  hi;
    logic [2:0]  off;
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] hi;
    logic [2:0] off;
    vt[0]  = '{32'h0300_0000, 4'h0, 32'h0,         1'b1, 32'h0000_0001, 32'h0000_0001, 32'h0};
    vt[1]  = '{32'h0300_0000, 4'h5, 32'hA5A5_A5A5, 1'b1, 32'h0000_0001, 32'h00A5_00A5, 32'h0};
    vt[2]  = '{32'h0300_0018, 4'hF, 32'h0000_FF00, 1'b1, 32'h0,         32'h00A5_FFA5, 32'h0};
    vt[3]  = '{32'h0300_001C, 4'hF, 32'h0000_0005, 1'b1, 32'h0,         32'h00A5_FFA0, 32'h0};
    vt[4]  = '{32'h0300_0000, 4'h0, 32'h0,         1'b1, 32'h00A5_FFA0, 32'h00A5_FFA0, 32'h0};
    vt[5]  = '{32'h0300_0004, 4'h3, 32'h1234_5678, 1'b1, 32'h0,         32'h00A5_FFA0, 32'h0000_5678};
    vt[6]  = '{32'h0300_0004, 4'h0, 32'h0,         1'b1, 32'h0000_5678, 32'h00A5_FFA0, 32'h0000_5678};
    vt[7]  = '{32'h0300_0008, 4'hF, 32'hFFFF_FFFF, 1'b1, 32'h0,         32'h00A5_FFA0, 32'h0000_5678};
    vt[8]  = '{32'h0500_000C, 4'hF, 32'hFFFF_FFFF, 1'b0, 32'h0,         32'h00A5_FFA0, 32'h0000_5678};
    vt[9]  = '{32'h0300_000C, 4'h0, 32'h0,         1'b1, 32'h0,         32'h00A5_FFA0, 32'h0000_5678};
    vt[10] = '{32'h0300_0010, 4'hC, 32'hAABB_CCDD, 1'b1, 32'h0,         32'h00A5_FFA0, 32'h0000_5678};
    vt[11] = '{32'h0300_0010, 4'h0, 32'h0,         1'b1, 32'hAABB_0000, 32'h00A5_FFA0, 32'h0000_5678};
    vt[12] = '{32'h0300_0020, 4'h0, 32'h0,         1'b1, 32'h00A5_FFA0, 32'h00A5_FFA0, 32'h0000_5678};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    check("rst_gpio_out", gpio_out, 32'h1);
    check("rst_gpio_oe", gpio_oe, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_ready", 32'(ready), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_out8", 32'(out8), 32'h1);
    check("rst_irq8", 32'(irq8), 32'h0);

    for (int i = 0; i < 13; i++) begin
      bus(vt[i].addr, vt[i].strb, vt[i].data);
      check($sformatf("vec%0d_ready", i), 32'(lat_ready), 32'(vt[i].rdy));
      check($sformatf("vec%0d_rdata", i), lat_rdata, vt[i].rdata);
      check($sformatf("vec%0d_out", i), lat_out, vt[i].out);
      check($sformatf("vec%0d_oe", i), lat_oe, vt[i].oe);
      check($sformatf("vec%0d_ready_drop", i), 32'(post_ready), 32'h0);
    end

    // Edge capture: pin0 rises, pin1 falls, with RISE_EN=1, FALL_EN=2.
    gpio_in = 32'h2;
    repeat (4) @(negedge clk);
    bus(32'h0300_0010, 4'hF, 32'h2);
    bus(32'h0300_000C, 4'hF, 32'h1);
    gpio_in = 32'h1;
    bus(32'h0300_0008, 4'h0, 32'h0);
    check("in_before_sync", lat_rdata, 32'h2);
    check("irq_before_status", 32'(irq), 32'h0);
    bus(32'h0300_0008, 4'h0, 32'h0);
    check("in_after_sync", lat_rdata, 32'h1);
    check("irq_rise", 32'(lat_irq), 32'h1);
    bus(32'h0300_0014, 4'h0, 32'h0);
    check("status_both", lat_rdata, 32'h3);
    bus(32'h0300_0014, 4'hF, 32'h1);
    check("w1c_read_before", lat_rdata, 32'h3);
    check("w1c0_irq", 32'(lat_irq), 32'h1);
    bus(32'h0300_0014, 4'h0, 32'h0);
    check("status_after_w1c0", lat_rdata, 32'h2);
    bus(32'h0300_0014, 4'hF, 32'h2);
    check("w1c1_irq", 32'(lat_irq), 32'h0);

    // Rising edge on pin 0 arrives at STATUS on the very edge a W1C of bit 0 lands.
    gpio_in = 32'h0;
    repeat (4) @(negedge clk);
    gpio_in = 32'h1;
    @(negedge clk);
    @(negedge clk);
    bus(32'h0300_0014, 4'hF, 32'h1);
    check("setwins_irq", 32'(lat_irq), 32'h1);
    bus(32'h0300_0014, 4'h0, 32'h0);
    check("setwins_status", lat_rdata, 32'h1);

    // Reset during the ready cycle of an OUT write.
    iomem_valid = 1'b1; iomem_addr = 32'h0300_0000; iomem_wstrb = 4'hF; iomem_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("rstmid_ready", 32'(ready), 32'h1);
    check("rstmid_out", gpio_out, 32'hDEAD_BEEF);
    reset = 1'b1; iomem_valid = 1'b0; iomem_wstrb = 4'h0;
    @(negedge clk);
    reset = 1'b0;
    check("rstmid_out_after", gpio_out, 32'h1);
    check("rstmid_ready_after", 32'(ready), 32'h0);
    check("rstmid_irq_after", 32'(irq), 32'h0);
    bus(32'h0300_0014, 4'h0, 32'h0);
    check("rstmid_status", lat_rdata, 32'h0);

    // Reset at the sampling edge drops the access entirely.
    iomem_valid = 1'b1; iomem_addr = 32'h0300_0000; iomem_wstrb = 4'hF; iomem_wdata = 32'h55;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; iomem_valid = 1'b0; iomem_wstrb = 4'h0;
    check("drop_ready", 32'(ready), 32'h0);
    check("drop_out", gpio_out, 32'h1);
    @(negedge clk);

    // Narrow instance at ADDR_HI 0x04: bits above WIDTH and block select.
    bus(32'h0400_0004, 4'hF, 32'hFFFF_FFFF);
    check("w8_ready8", 32'(lat_ready8), 32'h1);
    check("w8_ready32", 32'(lat_ready), 32'h0);
    check("w8_oe8", lat_oe8, 32'hFF);
    bus(32'h0400_0004, 4'h0, 32'h0);
    check("w8_dir_read", lat_rdata8, 32'h0000_00FF);
    bus(32'h0300_0004, 4'h0, 32'h0);
    check("w8_unsel_ready8", 32'(lat_ready8), 32'h0);
    check("w8_sel32_ready", 32'(lat_ready), 32'h1);

    // Randomized traffic, pins and occasional resets, checked by the model.
    for (int it = 0; it < 600; it++) begin
      if ($urandom_range(0, 3) == 0) gpio_in = $urandom;
      else if ($urandom_range(0, 1) == 0) gpio_in = gpio_in ^ (32'h1 << $urandom_range(0, 31));
      case ($urandom_range(0, 19))
        0: begin
          reset = 1'b1;
          @(negedge clk);
          reset = 1'b0;
        end
        1, 2, 3: @(negedge clk);
        default: begin
          hi  = ($urandom_range(0, 4) == 0) ? 8'h05 : 8'h03;
          off = 3'($urandom_range(0, 7));
          bus({hi, 19'h0, off, 2'b00},
              ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15)),
              $urandom);
        end
      endcase
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
